// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the fifo_stream_reader block: buffer occupancy encodings,
// beat counter width and the read-credit rule used to pace FIFO pops.
package fifo_stream_pkg;

    localparam int FSR_CNT_W = 2;

    localparam logic [FSR_CNT_W-1:0] CNT_EMPTY = 2'd0;
    localparam logic [FSR_CNT_W-1:0] CNT_ONE   = 2'd1;
    localparam logic [FSR_CNT_W-1:0] CNT_FULL  = 2'd2;

    localparam int BEAT_W = 16;

    // A new pop may only be issued if the words already owed to the buffer
    // (held + in flight - leaving this edge) leave a free slot for it.
    function automatic logic fsr_credit_ok(
        input logic [FSR_CNT_W-1:0] count,
        input logic                 inflight,
        input logic                 pop
    );
        logic [FSR_CNT_W:0] pending;
        pending = {1'b0, count}
                + {{FSR_CNT_W{1'b0}}, inflight}
                - {{FSR_CNT_W{1'b0}}, pop};
        return pending < {1'b0, CNT_FULL};
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO-side pop interface plus valid/ready output stream of fifo_stream_reader.
// out_last exists only when FSR_LAST_EN is defined.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
`ifdef FSR_LAST_EN
    logic                  out_last;
`endif

    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
`ifdef FSR_LAST_EN
        output out_last,
`endif
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
`ifdef FSR_LAST_EN
        input  out_last,
`endif
        input  out_valid
    );

endinterface

// File: rtl/fsr_skid_buf.sv
// Two-entry register buffer between the FIFO read port and the output stream.
// Data registers are not reset; rd_data reads as zero whenever the buffer is empty.
module fsr_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [FSR_CNT_W-1:0]  count
);

    logic [DATA_WIDTH-1:0] mem_p0 [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= CNT_EMPTY;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + FSR_CNT_W'(wr_en) - FSR_CNT_W'(rd_en);
        end
    end

    // Capture stage: a write with a simultaneous read at count 1 lands in the
    // slot the read pointer moves to, so it becomes the head next cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_p0[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = (count == CNT_EMPTY) ? '0 : mem_p0[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Converts sync_fifo's rd_en/empty pop port (1-cycle read latency) into a
// valid/ready stream. Define FSR_LAST_EN to add the out_last packet marker.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus
);

    logic                  inflight_p0;
    logic                  vld_p0;
    logic                  pop;
    logic                  rd_en;
    logic [FSR_CNT_W-1:0]  count;
    logic [DATA_WIDTH-1:0] head_data;

    assign vld_p0 = (count != CNT_EMPTY);
    assign pop    = vld_p0 && bus.out_ready;

    // Combinational on out_ready so a pop this edge frees a slot immediately,
    // which keeps one word per cycle flowing with ready held high.
    assign rd_en = !rst && !bus.fifo_empty && fsr_credit_ok(count, inflight_p0, pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_p0 <= 1'b0;
        end else begin
            inflight_p0 <= rd_en;
        end
    end

    fsr_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_p0),
        .wr_data (bus.fifo_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .count   (count)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = vld_p0;
    assign bus.out_data   = head_data;

`ifdef FSR_LAST_EN
    logic [BEAT_W-1:0] beat_p0;
    logic              last;

    assign last = vld_p0 && (beat_p0 == BEAT_W'(PKT_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_p0 <= '0;
        end else if (pop) begin
            beat_p0 <= last ? '0 : beat_p0 + 1'b1;
        end
    end

    assign bus.out_last = last;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: cycle table with the bench acting as the FIFO,
// then FIFO-model sequences for stalls, toggled ready, reset and (FSR_LAST_EN) out_last.
module tb_fifo_stream_reader;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Source selection: direct table drive or FIFO model
    logic          model_en;
    logic          tbl_empty;
    logic [DW-1:0] tbl_data;
    logic          ready;

    logic [DW-1:0] fmem [64];
    int            wr_idx;
    int            rd_idx;
    logic [DW-1:0] mdl_data;

    assign bus.fifo_empty = model_en ? (rd_idx == wr_idx) : tbl_empty;
    assign bus.fifo_data  = model_en ? mdl_data : tbl_data;
    assign bus.out_ready  = ready;

    always @(posedge clk) begin
        if (rst) begin
            rd_idx <= wr_idx;
        end else if (model_en && bus.fifo_rd_en && (rd_idx != wr_idx)) begin
            mdl_data <= fmem[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    task automatic push(input logic [DW-1:0] w);
        fmem[wr_idx] = w;
        wr_idx++;
    endtask

    // Monitor
    logic [DW-1:0] got [64];
    logic          got_last [64];
    int            got_n;
    int            rd_pulses;
    int            viol_rd_empty;
    int            viol_stall;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          last_now;

`ifdef FSR_LAST_EN
    assign last_now = bus.out_last;
`else
    assign last_now = 1'b0;
`endif

    always @(negedge clk) begin
        if (model_en && !rst) begin
            if (bus.fifo_rd_en && bus.fifo_empty) viol_rd_empty++;
            if (bus.fifo_rd_en) rd_pulses++;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || last_now !== prev_last))
                viol_stall++;
            if (bus.out_valid && bus.out_ready) begin
                got[got_n]      = bus.out_data;
                got_last[got_n] = last_now;
                got_n++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = last_now;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_got(input int base, input int n, input int budget);
        for (int i = 0; i < budget && (got_n - base) < n; i++) cyc(1);
    endtask

    typedef struct {
        logic          rst;
        logic          empty;
        logic [DW-1:0] data;
        logic          ready;
        logic          exp_rd;
        logic          exp_vld;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [22];

    initial begin
        int base;
        int pbase;
        logic [DW-1:0] w [8];

        rst = 1'b1; model_en = 1'b0; tbl_empty = 1'b1; tbl_data = '0; ready = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 32'h1555, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0AAA, 1'b1, 1'b0, 1'b1, 32'h1555};
        tbl[5]  = '{1'b0, 1'b1, 32'h0AAA, 1'b1, 1'b0, 1'b1, 32'h0AAA};
        tbl[6]  = '{1'b0, 1'b1, 32'h0AAA, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0AAA, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 32'hC3,   1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 32'hC3,   1'b0, 1'b0, 1'b1, 32'hC3};
        tbl[10] = '{1'b0, 1'b1, 32'hC3,   1'b0, 1'b0, 1'b1, 32'hC3};
        tbl[11] = '{1'b0, 1'b1, 32'hC3,   1'b1, 1'b0, 1'b1, 32'hC3};
        tbl[12] = '{1'b0, 1'b1, 32'hC3,   1'b1, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 32'hC3,   1'b0, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 32'h11,   1'b0, 1'b1, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 1'b0, 32'h22,   1'b0, 1'b0, 1'b1, 32'h11};
        tbl[16] = '{1'b0, 1'b0, 32'h22,   1'b0, 1'b0, 1'b1, 32'h11};
        tbl[17] = '{1'b0, 1'b0, 32'h22,   1'b1, 1'b1, 1'b1, 32'h11};
        tbl[18] = '{1'b0, 1'b1, 32'h33,   1'b0, 1'b0, 1'b1, 32'h22};
        tbl[19] = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b0, 1'b1, 32'h22};
        tbl[20] = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b0, 1'b1, 32'h33};
        tbl[21] = '{1'b0, 1'b1, 32'h33,   1'b1, 1'b0, 1'b0, 32'h0};

        cyc(1);
        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].rst; tbl_empty = tbl[i].empty; tbl_data = tbl[i].data; ready = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("row%0d rd_en", i), bus.fifo_rd_en, tbl[i].exp_rd);
            chk($sformatf("row%0d valid", i), bus.out_valid, tbl[i].exp_vld);
            chk($sformatf("row%0d data", i), bus.out_data, tbl[i].exp_data);
            @(posedge clk);
            #1;
        end

        // Stall with four queued words: exactly two pops, head held
        model_en = 1'b1; ready = 1'b0; rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w[i] = 32'h3000_0000 + i;
            push(w[i]);
        end
        pbase = rd_pulses;
        cyc(8);
        chk("stall rd_en pulses", rd_pulses - pbase, 2);
        chk("stall valid", bus.out_valid, 1'b1);
        chk("stall head", bus.out_data, w[0]);
        chk("stall rd_en low", bus.fifo_rd_en, 1'b0);
        base = got_n;
        ready = 1'b1;
        wait_got(base, 4, 40);
        chk("stall drain count", got_n - base, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("stall word%0d", i), got[base + i], w[i]);

        // Toggled ready with eight queued words
        cyc(2);
        for (int i = 0; i < 8; i++) begin
            w[i] = 32'hA500_0000 + (i * 32'h111);
            push(w[i]);
        end
        base = got_n;
        for (int i = 0; i < 80 && (got_n - base) < 8; i++) begin
            ready = (i % 2 == 0);
            cyc(1);
        end
        ready = 1'b0;
        chk("toggle count", got_n - base, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("toggle word%0d", i), got[base + i], w[i]);
        cyc(3);
        chk("toggle no extra", got_n - base, 8);

        // Reset while a word is held and another is in flight
        for (int i = 0; i < 3; i++) push(32'h5000_0000 + i);
        cyc(2);
        chk("pre-reset valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("post-reset valid", bus.out_valid, 1'b0);
        chk("post-reset data", bus.out_data, 32'h0);
        chk("post-reset rd_en", bus.fifo_rd_en, 1'b0);
        base = got_n;
        push(32'hDEAD);
        ready = 1'b1;
        wait_got(base, 1, 20);
        cyc(4);
        chk("reset first count", got_n - base, 1);
        chk("reset first word", got[base], 32'hDEAD);

`ifdef FSR_LAST_EN
        // PKT_LEN=3: out_last on beats 3 and 6, held while stalled on beat 6
        ready = 1'b0; rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) push(32'h7000_0000 + i);
        base = got_n;
        ready = 1'b1;
        wait_got(base, 5, 40);
        ready = 1'b0;
        chk("last pre-stall count", got_n - base, 5);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk($sformatf("last stall valid c%0d", i), bus.out_valid, 1'b1);
            chk($sformatf("last stall flag c%0d", i), bus.out_last, 1'b1);
            chk($sformatf("last stall data c%0d", i), bus.out_data, 32'h7000_0005);
        end
        ready = 1'b1;
        wait_got(base, 7, 40);
        chk("last beat count", got_n - base, 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("last beat%0d", i + 1), got_last[base + i], (i == 2 || i == 5));
        cyc(2);
        chk("last idle", bus.out_last, 1'b0);
`endif

        chk("rd_en while empty", viol_rd_empty, 0);
        chk("stall stability", viol_stall, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
